// File: rtl/forward_control.sv
// Data-hazard forwarding unit: produces EX operand bypass selects, both combinational and registered.
// Optional forward-usage counters are enabled by defining FWD_STATS_EN.
module forward_control #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_RegWEN,
  input  logic              MEM_WB_RegWEN,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [REG_AW-1:0] Rd_MA,
  input  logic [REG_AW-1:0] Rs1_ID,
  input  logic [REG_AW-1:0] Rs2_ID,
  input  logic              Stall,
  input  logic              Flush,
  output logic [SEL_W-1:0]  Fw_1,
  output logic [SEL_W-1:0]  Fw_2,
  output logic [1:0]        Fw_Detected,
  output logic [SEL_W-1:0]  Fw_1_EX,
  output logic [SEL_W-1:0]  Fw_2_EX
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]       Mem_Fw_Cnt,
  output logic [15:0]       Wb_Fw_Cnt
`endif
);

  localparam logic [SEL_W-1:0] NO_FW  = SEL_W'(0);
  localparam logic [SEL_W-1:0] WB_FW  = SEL_W'(1);
  localparam logic [SEL_W-1:0] MEM_FW = SEL_W'(2);

  logic mem_hit_1, mem_hit_2, wb_hit_1, wb_hit_2;
  logic capture;

  // x0 is hardwired to zero, so a write to it must never be bypassed.
  assign mem_hit_1 = EX_MEM_RegWEN && (Rd_EX != '0) && (Rd_EX == Rs1_ID);
  assign mem_hit_2 = EX_MEM_RegWEN && (Rd_EX != '0) && (Rd_EX == Rs2_ID);
  assign wb_hit_1  = MEM_WB_RegWEN && (Rd_MA != '0) && (Rd_MA == Rs1_ID);
  assign wb_hit_2  = MEM_WB_RegWEN && (Rd_MA != '0) && (Rd_MA == Rs2_ID);

  always_comb begin
    // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
    Fw_1 = NO_FW;
    Fw_2 = NO_FW;
    // EX/MEM holds the younger result, so it wins over MEM/WB.
    if (mem_hit_1)     Fw_1 = MEM_FW;
    else if (wb_hit_1) Fw_1 = WB_FW;
    if (mem_hit_2)     Fw_2 = MEM_FW;
    else if (wb_hit_2) Fw_2 = WB_FW;
  end

  assign Fw_Detected = {(Fw_2 != NO_FW), (Fw_1 != NO_FW)};

  // New selects enter the EX stage only when the pipeline advances without a bubble.
  assign capture = !Flush && !Stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Fw_1_EX <= NO_FW;
      Fw_2_EX <= NO_FW;
    end else if (Flush) begin
      Fw_1_EX <= NO_FW;
      Fw_2_EX <= NO_FW;
    end else if (!Stall) begin
      Fw_1_EX <= Fw_1;
      Fw_2_EX <= Fw_2;
    end
  end

`ifdef FWD_STATS_EN
  logic [1:0]  mem_inc, wb_inc;
  logic [16:0] mem_sum, wb_sum;

  assign mem_inc = {1'b0, (Fw_1 == MEM_FW)} + {1'b0, (Fw_2 == MEM_FW)};
  assign wb_inc  = {1'b0, (Fw_1 == WB_FW)}  + {1'b0, (Fw_2 == WB_FW)};
  assign mem_sum = {1'b0, Mem_Fw_Cnt} + 17'(mem_inc);
  assign wb_sum  = {1'b0, Wb_Fw_Cnt}  + 17'(wb_inc);

  // The carry bit of each sum flags overflow; the counter then pins at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Mem_Fw_Cnt <= '0;
      Wb_Fw_Cnt  <= '0;
    end else if (capture) begin
      Mem_Fw_Cnt <= mem_sum[16] ? 16'hFFFF : mem_sum[15:0];
      Wb_Fw_Cnt  <= wb_sum[16]  ? 16'hFFFF : wb_sum[15:0];
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_forward_control.sv
// Directed self-checking bench for forward_control; covers the stats counters when FWD_STATS_EN is defined.
module tb_forward_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       EX_MEM_RegWEN, MEM_WB_RegWEN;
  logic [4:0] Rd_EX, Rd_MA, Rs1_ID, Rs2_ID;
  logic       Stall, Flush;
  logic [1:0] Fw_1, Fw_2, Fw_Detected, Fw_1_EX, Fw_2_EX;
`ifdef FWD_STATS_EN
  logic [15:0] Mem_Fw_Cnt, Wb_Fw_Cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  forward_control dut (
    .clk(clk), .rst(rst),
    .EX_MEM_RegWEN(EX_MEM_RegWEN), .MEM_WB_RegWEN(MEM_WB_RegWEN),
    .Rd_EX(Rd_EX), .Rd_MA(Rd_MA), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .Stall(Stall), .Flush(Flush),
    .Fw_1(Fw_1), .Fw_2(Fw_2), .Fw_Detected(Fw_Detected),
    .Fw_1_EX(Fw_1_EX), .Fw_2_EX(Fw_2_EX)
`ifdef FWD_STATS_EN
    , .Mem_Fw_Cnt(Mem_Fw_Cnt), .Wb_Fw_Cnt(Wb_Fw_Cnt)
`endif
  );

  task automatic drive(input logic ew, input logic mw, input logic [4:0] rdx,
                       input logic [4:0] rdm, input logic [4:0] r1, input logic [4:0] r2);
    EX_MEM_RegWEN = ew; MEM_WB_RegWEN = mw;
    Rd_EX = rdx; Rd_MA = rdm; Rs1_ID = r1; Rs2_ID = r2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (Fw_1_EX !== 2'b00) begin bad++; $display("FAIL reset_fw1_ex got=%b exp=00", Fw_1_EX); end
    total++; if (Fw_2_EX !== 2'b00) begin bad++; $display("FAIL reset_fw2_ex got=%b exp=00", Fw_2_EX); end
`ifdef FWD_STATS_EN
    total++; if (Mem_Fw_Cnt !== 16'd0) begin bad++; $display("FAIL reset_mem_cnt got=%0d exp=0", Mem_Fw_Cnt); end
    total++; if (Wb_Fw_Cnt !== 16'd0) begin bad++; $display("FAIL reset_wb_cnt got=%0d exp=0", Wb_Fw_Cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    total++; if (Fw_1 !== 2'b00) begin bad++; $display("FAIL x0_fw1 got=%b exp=00", Fw_1); end
    total++; if (Fw_2 !== 2'b00) begin bad++; $display("FAIL x0_fw2 got=%b exp=00", Fw_2); end
    total++; if (Fw_Detected !== 2'b00) begin bad++; $display("FAIL x0_det got=%b exp=00", Fw_Detected); end
  endtask

  task automatic test_mem_fw();
    drive(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 5'd0);
    total++; if (Fw_1 !== 2'b10) begin bad++; $display("FAIL mem_fw1 got=%b exp=10", Fw_1); end
    total++; if (Fw_2 !== 2'b00) begin bad++; $display("FAIL mem_fw2_none got=%b exp=00", Fw_2); end
    total++; if (Fw_Detected !== 2'b01) begin bad++; $display("FAIL mem_det_01 got=%b exp=01", Fw_Detected); end
    drive(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 5'd1);
    total++; if (Fw_2 !== 2'b10) begin bad++; $display("FAIL mem_fw2 got=%b exp=10", Fw_2); end
    total++; if (Fw_Detected !== 2'b11) begin bad++; $display("FAIL mem_det_11 got=%b exp=11", Fw_Detected); end
    // Matching register but write enable low: no forward.
    drive(1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 5'd1);
    total++; if (Fw_1 !== 2'b00) begin bad++; $display("FAIL no_wen_fw1 got=%b exp=00", Fw_1); end
  endtask

  task automatic test_wb_priority();
    drive(1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 5'd3);
    total++; if (Fw_2 !== 2'b01) begin bad++; $display("FAIL wb_fw2 got=%b exp=01", Fw_2); end
    total++; if (Fw_Detected !== 2'b10) begin bad++; $display("FAIL wb_det got=%b exp=10", Fw_Detected); end
    drive(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 5'd3);
    total++; if (Fw_2 !== 2'b10) begin bad++; $display("FAIL prio_fw2 got=%b exp=10", Fw_2); end
    drive(1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 5'd3);
    total++; if (Fw_2 !== 2'b00) begin bad++; $display("FAIL nomatch_fw2 got=%b exp=00", Fw_2); end
    drive(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 5'd3);
    total++; if (Fw_1 !== 2'b10) begin bad++; $display("FAIL both_match_fw1 got=%b exp=10", Fw_1); end
    // x0 in EX/MEM must not mask a valid MEM/WB forward.
    drive(1'b1, 1'b1, 5'd0, 5'd7, 5'd7, 5'd0);
    total++; if (Fw_1 !== 2'b01) begin bad++; $display("FAIL x0_ex_wb_fw1 got=%b exp=01", Fw_1); end
  endtask

  task automatic test_registered();
    @(posedge clk); #1;
    Stall = 1'b0; Flush = 1'b0;
    drive(1'b1, 1'b0, 5'd1, 5'd0, 5'd1, 5'd0);
    @(posedge clk); #1;
    total++; if (Fw_1_EX !== 2'b10) begin bad++; $display("FAIL reg_capture got=%b exp=10", Fw_1_EX); end
    total++; if (Fw_2_EX !== 2'b00) begin bad++; $display("FAIL reg_capture_fw2 got=%b exp=00", Fw_2_EX); end
    Stall = 1'b1;
    drive(1'b0, 1'b1, 5'd0, 5'd1, 5'd1, 5'd0);
    total++; if (Fw_1 !== 2'b01) begin bad++; $display("FAIL stall_comb got=%b exp=01", Fw_1); end
    @(posedge clk); #1;
    total++; if (Fw_1_EX !== 2'b10) begin bad++; $display("FAIL stall_hold got=%b exp=10", Fw_1_EX); end
    Flush = 1'b1;
    @(posedge clk); #1;
    total++; if (Fw_1_EX !== 2'b00) begin bad++; $display("FAIL flush_over_stall got=%b exp=00", Fw_1_EX); end
    Flush = 1'b0; Stall = 1'b0;
    @(posedge clk); #1;
    total++; if (Fw_1_EX !== 2'b01) begin bad++; $display("FAIL resume_capture got=%b exp=01", Fw_1_EX); end
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (Fw_1_EX !== 2'b00) begin bad++; $display("FAIL async_rst_fw1 got=%b exp=00", Fw_1_EX); end
    total++; if (Fw_1 !== 2'b01) begin bad++; $display("FAIL comb_during_rst got=%b exp=01", Fw_1); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (Fw_1_EX !== 2'b01) begin bad++; $display("FAIL post_rst_capture got=%b exp=01", Fw_1_EX); end
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd5, 5'd6, 5'd5, 5'd6);
    repeat (3) @(posedge clk);
    #1;
    total++; if (Mem_Fw_Cnt !== 16'd3) begin bad++; $display("FAIL stats_mem got=%0d exp=3", Mem_Fw_Cnt); end
    total++; if (Wb_Fw_Cnt !== 16'd3) begin bad++; $display("FAIL stats_wb got=%0d exp=3", Wb_Fw_Cnt); end
    Stall = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 5'd6, 5'd5, 5'd5);
    @(posedge clk); #1;
    total++; if (Mem_Fw_Cnt !== 16'd3) begin bad++; $display("FAIL stats_stall_hold got=%0d exp=3", Mem_Fw_Cnt); end
    Stall = 1'b0;
    @(posedge clk); #1;
    total++; if (Mem_Fw_Cnt !== 16'd5) begin bad++; $display("FAIL stats_double got=%0d exp=5", Mem_Fw_Cnt); end
    rst = 1'b1; #1;
    total++; if (Mem_Fw_Cnt !== 16'd0) begin bad++; $display("FAIL stats_rst_mem got=%0d exp=0", Mem_Fw_Cnt); end
    total++; if (Wb_Fw_Cnt !== 16'd0) begin bad++; $display("FAIL stats_rst_wb got=%0d exp=0", Wb_Fw_Cnt); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_x0();
    test_mem_fw();
    test_wb_priority();
    test_registered();
    test_async_reset();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_control.md
Name: forward_control

Overview:
- Data-hazard forwarding unit for the 5-stage RISC-V pipeline.
- Compares the ID-stage source registers against the destination registers of the instructions currently in EX/MEM and MEM/WB.
- Produces per-operand bypass selects, combinationally for same-cycle use and registered for the EX stage.
- Sits beside the ID/EX pipeline register and drives the EX operand muxes.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- SEL_W, 2, forward-select width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- EX_MEM_RegWEN  in  1  instruction in EX/MEM writes a register.
- MEM_WB_RegWEN  in  1  instruction in MEM/WB writes a register.
- Rd_EX  in  5  destination register of the EX/MEM instruction.
- Rd_MA  in  5  destination register of the MEM/WB instruction.
- Rs1_ID  in  5  source register 1 of the ID instruction.
- Rs2_ID  in  5  source register 2 of the ID instruction.
- Stall  in  1  hold the registered selects.
- Flush  in  1  clear the registered selects (bubble).
- Fw_1  out  2  combinational select for operand 1.
- Fw_2  out  2  combinational select for operand 2.
- Fw_Detected  out  2  combinational flags: bit0 = operand 1 forwarded, bit1 = operand 2 forwarded.
- Fw_1_EX  out  2  registered Fw_1 for the EX stage.
- Fw_2_EX  out  2  registered Fw_2 for the EX stage.

Behaviour:
- Select encoding: 2'b00 No_Fw (register file), 2'b01 WB_Fw (MEM/WB result), 2'b10 MEM_Fw (EX/MEM result). 2'b11 is never driven.
- Per operand n (Rs = Rs1_ID or Rs2_ID), evaluated in priority order:
  - If EX_MEM_RegWEN=1, Rd_EX!=0 and Rd_EX==Rs: select MEM_Fw.
  - Else if MEM_WB_RegWEN=1, Rd_MA!=0 and Rd_MA==Rs: select WB_Fw.
  - Else: select No_Fw.
- MEM_Fw has priority because EX/MEM holds the newest value when both stages match.
- x0 is never forwarded, regardless of write enables.
- Fw_Detected[0] = (Fw_1 != 00); Fw_Detected[1] = (Fw_2 != 00).
- Fw_1, Fw_2 and Fw_Detected are purely combinational, with zero latency and no dependence on clk or rst.
- Registered selects, updated on the rising edge of clk:
  - rst=1 (asynchronous): Fw_1_EX = Fw_2_EX = 00 immediately.
  - Flush=1: load 00 into both, even when Stall=1 (Flush wins over Stall).
  - Stall=1 with Flush=0: hold the current values.
  - Otherwise: Fw_1_EX <= Fw_1, Fw_2_EX <= Fw_2.
- Release of reset takes effect at the next edge; there are no other state elements.
- Unknown (X) inputs are not sanitized.

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, add these outputs:
  - Mem_Fw_Cnt  out  16: counts clock edges where a MEM_Fw select is captured into Fw_1_EX or Fw_2_EX (not stalled or flushed).
  - Wb_Fw_Cnt  out  16: same, for WB_Fw.
- Each counter increments by 1 per operand, so by 2 when both operands use that source.
- Counters saturate at 16'hFFFF and are cleared by rst.
- When the macro is undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- EX_MEM_RegWEN=1, Rd_EX=0, Rs1_ID=0, Rs2_ID=0 -> Fw_1=00, Fw_2=00, Fw_Detected=00 (x0 excluded).
- EX_MEM_RegWEN=1, Rd_EX=1, Rs1_ID=1, Rs2_ID=0 -> Fw_1=10, Fw_2=00, Fw_Detected=01; then Rs2_ID=1 -> Fw_2=10, Fw_Detected=11.
- EX_MEM_RegWEN=0, MEM_WB_RegWEN=1, Rd_MA=3, Rs2_ID=3 -> Fw_2=01. With EX_MEM_RegWEN=1 and Rd_EX=3 in addition -> Fw_2=10 (priority).
- Rs2_ID=3, Rd_EX=1, Rd_MA=1, both enables 1 -> Fw_2=00; Rs1_ID=1 -> Fw_1=10.
- Registered path:
  - Fw_1=10 before edge -> Fw_1_EX=10 after edge.
  - Stall=1 with Fw_1 changed to 01 -> Fw_1_EX stays 10.
  - Flush=1 and Stall=1 together -> Fw_1_EX=00 after edge.
  - Assert rst mid-cycle -> Fw_1_EX=00 immediately, without waiting for an edge.
- With FWD_STATS_EN defined: 3 edges with Fw_1=10 and Fw_2=01 -> Mem_Fw_Cnt=3, Wb_Fw_Cnt=3; rst -> both 0.
